// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and lowercase-sigma helpers for the message schedule.
// The compression core reuses this package for its own round functions.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;

  typedef logic [31:0]       word_t;
  typedef logic [0:15][31:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    HOLD
  } sched_state_e;

  function automatic word_t sig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t sig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational next-schedule-word: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module sha256_sched_word
  import sha256_pkg::*;
(
  input  word_t w2,
  input  word_t w7,
  input  word_t w15,
  input  word_t w16,
  output word_t w_new
);

  assign w_new = sig1(w2) + w7 + sig0(w15) + w16;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads a 512-bit block, expands to W[0..ROUNDS-1].
// Optional macro SHA256_SCHED_STREAM_EN adds per-word streaming outputs ws_valid/ws_idx/ws_data.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [511:0]            blk_data,
  output logic [0:ROUNDS-1][31:0] w,
  output logic                    w_valid,
  input  logic                    w_ack,
`ifdef SHA256_SCHED_STREAM_EN
  output logic                    ws_valid,
  output logic [5:0]              ws_idx,
  output logic [31:0]             ws_data,
`endif
  output logic                    busy
);

  localparam int IW = $clog2(ROUNDS);

  sched_state_e state_reg, state_next;
  logic [6:0]   t_reg;
  word_t        w_reg [0:ROUNDS-1];
  block_t       blk_words;
  logic         accept;
  logic [6:0]   t_m2, t_m7, t_m15, t_m16;
  word_t        w_new;

  assign blk_words = blk_data;
  assign accept    = (state_reg == IDLE) && blk_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    blk_ready  = 1'b0;
    w_valid    = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) state_next = EXPAND;
      end
      EXPAND: begin
        if (t_reg == 7'(ROUNDS - 1)) state_next = HOLD;
      end
      HOLD: begin
        w_valid = 1'b1;
        if (w_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign t_m2  = t_reg - 7'd2;
  assign t_m7  = t_reg - 7'd7;
  assign t_m15 = t_reg - 7'd15;
  assign t_m16 = t_reg - 7'd16;

  sha256_sched_word u_word (
    .w2    (w_reg[t_m2[IW-1:0]]),
    .w7    (w_reg[t_m7[IW-1:0]]),
    .w15   (w_reg[t_m15[IW-1:0]]),
    .w16   (w_reg[t_m16[IW-1:0]]),
    .w_new (w_new)
  );

  // Array is written in place: 16 words on accept, then one word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_reg <= '0;
      for (int i = 0; i < ROUNDS; i++) w_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) w_reg[i] <= blk_words[i];
      t_reg <= 7'd16;
    end else if (state_reg == EXPAND) begin
      w_reg[t_reg[IW-1:0]] <= w_new;
      t_reg                <= t_reg + 7'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROUNDS; gi++) begin : g_w_out
      assign w[gi] = w_reg[gi];
    end
  endgenerate

`ifdef SHA256_SCHED_STREAM_EN
  assign ws_valid = (state_reg == EXPAND);
  assign ws_idx   = t_reg[5:0];
  assign ws_data  = w_new;
`endif

endmodule
